burst_line_adapter: RTL and testbench

//  Responder for the 256-bit cacheline DFP interface used by the I-cache prefetcher and the D-cache.

---
 rtl/burst_line_adapter_pkg.sv | 20 ++
 rtl/burst_line_adapter.sv | 149 ++++++++++++++
 tb/tb_burst_line_adapter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_line_adapter_pkg.sv
// rtl/burst_line_adapter_pkg.sv - shared types and sizes for the cacheline burst adapter
package burst_line_adapter_pkg;

    localparam int BEATS       = 4;
    localparam int BEAT_W      = 64;
    localparam int LINE_W      = BEATS * BEAT_W;
    localparam int OFFSET_BITS = 5;
    localparam int CNT_W       = $clog2(BEATS);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_DATA = 3'd2,
        WR_DATA = 3'd3,
        RESP    = 3'd4
    } adapter_state_t;

endpackage

// File: rtl/burst_line_adapter.sv
// rtl/burst_line_adapter.sv - converts one 256-bit line read/write into a 4-beat 64-bit bmem burst
module burst_line_adapter
    import burst_line_adapter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [31:0]       dfp_addr,
    input  logic              dfp_read,
    input  logic              dfp_write,
    input  logic [LINE_W-1:0] dfp_wdata,
    output logic [LINE_W-1:0] dfp_rdata,
    output logic              dfp_resp,
    output logic [31:0]       dfp_raddr,
    output logic [31:0]       bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [31:0]       bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
);

    adapter_state_t    state, state_d;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       addr_r;
    logic [LINE_W-1:0] wbuf;
    logic [LINE_W-1:0] rbuf;
    logic              drop_r;
    logic              wr_r;
    logic              beat_hit;
    logic              unused_bits;

    // Offset bits are irrelevant: requests and beat tags compare at line granularity.
    assign unused_bits = ^{dfp_addr[OFFSET_BITS-1:0], bmem_raddr[OFFSET_BITS-1:0]};

    assign beat_hit = bmem_rvalid &&
                      (bmem_raddr[31:OFFSET_BITS] == addr_r[31:OFFSET_BITS]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_r <= '0;
            wbuf   <= '0;
            rbuf   <= '0;
            drop_r <= 1'b0;
            wr_r   <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    // A request accepted together with flush starts clean.
                    if (dfp_write || dfp_read) begin
                        addr_r <= {dfp_addr[31:OFFSET_BITS], OFFSET_BITS'(0)};
                        wr_r   <= dfp_write;
                        cnt    <= '0;
                        drop_r <= 1'b0;
                        if (dfp_write) begin
                            wbuf <= dfp_wdata;
                        end
                    end
                end
                RD_REQ: begin
                    if (flush) begin
                        drop_r <= 1'b1;
                    end
                    if (bmem_ready) begin
                        cnt <= '0;
                    end
                end
                RD_DATA: begin
                    if (flush) begin
                        drop_r <= 1'b1;
                    end
                    if (beat_hit) begin
                        rbuf[int'(cnt)*BEAT_W +: BEAT_W] <= bmem_rdata;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WR_DATA: begin
                    if (bmem_ready) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    drop_r <= 1'b0;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        state_d    = state;
        dfp_rdata  = '0;
        dfp_resp   = 1'b0;
        dfp_raddr  = '0;
        bmem_addr  = '0;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_wdata = '0;
        case (state)
            IDLE: begin
                if (dfp_write) begin
                    state_d = WR_DATA;
                end else if (dfp_read) begin
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                bmem_read = 1'b1;
                bmem_addr = addr_r;
                if (bmem_ready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (beat_hit && (cnt == LAST_BEAT)) begin
                    state_d = RESP;
                end
            end
            WR_DATA: begin
                bmem_write = 1'b1;
                bmem_addr  = addr_r;
                bmem_wdata = wbuf[int'(cnt)*BEAT_W +: BEAT_W];
                if (bmem_ready && (cnt == LAST_BEAT)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
                // Writes always complete; a flushed read is silently dropped.
                if (wr_r || !(drop_r || flush)) begin
                    dfp_resp  = 1'b1;
                    dfp_raddr = addr_r;
                    dfp_rdata = wr_r ? '0 : rbuf;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_burst_line_adapter.sv
// tb/tb_burst_line_adapter.sv - directed self-checking bench for burst_line_adapter
module tb_burst_line_adapter;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  dfp_raddr;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int n_pass;
    int n_total;

    burst_line_adapter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .dfp_addr    (dfp_addr),
        .dfp_read    (dfp_read),
        .dfp_write   (dfp_write),
        .dfp_wdata   (dfp_wdata),
        .dfp_rdata   (dfp_rdata),
        .dfp_resp    (dfp_resp),
        .dfp_raddr   (dfp_raddr),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_resp"},  256'(dfp_resp),   256'(0));
        chk({tag, "_rd"},    256'(bmem_read),  256'(0));
        chk({tag, "_wr"},    256'(bmem_write), 256'(0));
        chk({tag, "_baddr"}, 256'(bmem_addr),  256'(0));
        chk({tag, "_rdata"}, dfp_rdata,        256'(0));
        chk({tag, "_raddr"}, 256'(dfp_raddr),  256'(0));
    endtask

    task automatic beat(input logic [31:0] a, input logic [63:0] d);
        bmem_rvalid = 1'b1;
        bmem_raddr  = a;
        bmem_rdata  = d;
        step();
        bmem_rvalid = 1'b0;
    endtask

    // Full read from IDLE with immediate ready and back-to-back beats.
    task automatic rd_line(input string tag, input logic [31:0] a, input logic [31:0] ea,
                           input logic [255:0] line, input logic exp_resp);
        dfp_addr   = a;
        dfp_read   = 1'b1;
        bmem_ready = 1'b1;
        step();
        dfp_read = 1'b0;
        chk({tag, "_bmem_read"}, 256'(bmem_read), 256'(1));
        chk({tag, "_bmem_addr"}, 256'(bmem_addr), 256'(ea));
        step();
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_early_resp"}, 256'(dfp_resp), 256'(0));
            beat(ea, line[i*64 +: 64]);
        end
        chk({tag, "_resp"}, 256'(dfp_resp), 256'(exp_resp));
        if (exp_resp) begin
            chk({tag, "_raddr"}, 256'(dfp_raddr), 256'(ea));
            chk({tag, "_rdata"}, dfp_rdata, line);
        end
        step();
        chk({tag, "_resp_gone"}, 256'(dfp_resp), 256'(0));
    endtask

    logic [63:0] wexp [6];
    logic        wrdy [6];

    initial begin
        n_pass      = 0;
        n_total     = 0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        dfp_addr    = '0;
        dfp_read    = 1'b0;
        dfp_write   = 1'b0;
        dfp_wdata   = '0;
        bmem_ready  = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        bmem_rvalid = 1'b0;
        step();
        step();
        chk_quiet("reset");
        rst_n = 1'b1;
        step();

        // 1: basic read, aligned address, beat ordering
        rd_line("t1", 32'h0000_1234, 32'h0000_1220,
                {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 1'b1);

        // 2: write with ready stalls
        wrdy[0] = 1'b1; wexp[0] = 64'hAAAA_0000_0000_0001;
        wrdy[1] = 1'b0; wexp[1] = 64'hBBBB_0000_0000_0002;
        wrdy[2] = 1'b1; wexp[2] = 64'hBBBB_0000_0000_0002;
        wrdy[3] = 1'b0; wexp[3] = 64'hCCCC_0000_0000_0003;
        wrdy[4] = 1'b1; wexp[4] = 64'hCCCC_0000_0000_0003;
        wrdy[5] = 1'b1; wexp[5] = 64'hDDDD_0000_0000_0004;
        dfp_addr   = 32'h0000_0080;
        dfp_write  = 1'b1;
        dfp_wdata  = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003,
                      64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
        bmem_ready = 1'b0;
        step();
        dfp_write = 1'b0;
        chk("t2_bmem_addr", 256'(bmem_addr), 256'(32'h80));
        for (int j = 0; j < 6; j++) begin
            bmem_ready = wrdy[j];
            chk($sformatf("t2_write_%0d", j), 256'(bmem_write), 256'(1));
            chk($sformatf("t2_wdata_%0d", j), 256'(bmem_wdata), 256'(wexp[j]));
            step();
        end
        bmem_ready = 1'b0;
        chk("t2_resp", 256'(dfp_resp), 256'(1));
        chk("t2_raddr", 256'(dfp_raddr), 256'(32'h80));
        chk("t2_bmem_write_off", 256'(bmem_write), 256'(0));
        step();
        chk("t2_resp_gone", 256'(dfp_resp), 256'(0));

        // 3: address changes after acceptance
        dfp_addr   = 32'h0000_0040;
        dfp_read   = 1'b1;
        bmem_ready = 1'b1;
        step();
        chk("t3_bmem_addr", 256'(bmem_addr), 256'(32'h40));
        step();
        dfp_addr = 32'h0000_0060;
        for (int i = 0; i < 4; i++) beat(32'h40, 64'h4000 + 64'(i));
        chk("t3_resp", 256'(dfp_resp), 256'(1));
        chk("t3_raddr", 256'(dfp_raddr), 256'(32'h40));
        chk("t3_rdata", dfp_rdata, {64'h4003, 64'h4002, 64'h4001, 64'h4000});
        step();
        chk("t3_idle_gap", 256'(bmem_read), 256'(0));
        step();
        chk("t3_second_read", 256'(bmem_read), 256'(1));
        chk("t3_second_addr", 256'(bmem_addr), 256'(32'h60));
        dfp_read = 1'b0;
        step();
        for (int i = 0; i < 4; i++) beat(32'h60, 64'h6000 + 64'(i));
        chk("t3_resp2", 256'(dfp_resp), 256'(1));
        chk("t3_raddr2", 256'(dfp_raddr), 256'(32'h60));
        step();

        // 4: gapped beats and a foreign beat
        dfp_addr = 32'h0000_0200;
        dfp_read = 1'b1;
        step();
        dfp_read = 1'b0;
        step();
        beat(32'h200, 64'hB0);
        beat(32'h200, 64'hB1);
        step();
        beat(32'h0000_FFE0, 64'hDEAD_BEEF);
        step();
        beat(32'h200, 64'hB2);
        chk("t4_no_early_resp", 256'(dfp_resp), 256'(0));
        step();
        beat(32'h200, 64'hB3);
        chk("t4_resp", 256'(dfp_resp), 256'(1));
        chk("t4_raddr", 256'(dfp_raddr), 256'(32'h200));
        chk("t4_rdata", dfp_rdata, {64'hB3, 64'hB2, 64'hB1, 64'hB0});
        step();

        // 5: flush mid-read drops the response only
        dfp_addr = 32'h0000_0100;
        dfp_read = 1'b1;
        step();
        dfp_read = 1'b0;
        step();
        beat(32'h100, 64'hC0);
        beat(32'h100, 64'hC1);
        flush = 1'b1;
        beat(32'h100, 64'hC2);
        flush = 1'b0;
        beat(32'h100, 64'hC3);
        chk("t5_dropped", 256'(dfp_resp), 256'(0));
        step();
        chk("t5_idle", 256'(dfp_resp), 256'(0));
        rd_line("t5b", 32'h0000_0120, 32'h0000_0120,
                {64'hE3, 64'hE2, 64'hE1, 64'hE0}, 1'b1);

        // 6: reset in the middle of a read
        dfp_addr = 32'h0000_0300;
        dfp_read = 1'b1;
        step();
        dfp_read = 1'b0;
        step();
        beat(32'h300, 64'hF0);
        rst_n = 1'b0;
        step();
        chk_quiet("t6_reset");
        rst_n = 1'b1;
        rd_line("t6b", 32'h0000_0340, 32'h0000_0340,
                {64'h73, 64'h72, 64'h71, 64'h70}, 1'b1);

        // 7: flush held through a write still yields a response
        dfp_addr   = 32'h0000_0500;
        dfp_write  = 1'b1;
        dfp_wdata  = {64'h4, 64'h3, 64'h2, 64'h1};
        bmem_ready = 1'b1;
        flush      = 1'b1;
        step();
        dfp_write = 1'b0;
        repeat (4) step();
        chk("t7_resp", 256'(dfp_resp), 256'(1));
        chk("t7_raddr", 256'(dfp_raddr), 256'(32'h500));
        flush = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
